stream_muxn: RTL and testbench
==============================

STREAM_MUXN -- requirements
Module: stream_muxn

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the data width in bits of every input channel and of the output.
REQ-002 Parameter N, default 4, SHALL set the input channel count (N >= 2); SW = $clog2(N).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 sel  input  SW  SHALL select the source channel.
REQ-006 in_data  input  N x WIDTH  SHALL carry per-channel data.
REQ-007 in_valid  input  N  SHALL carry per-channel valid.
REQ-008 in_last  input  N  SHALL mark the last beat of a packet, per channel.
REQ-009 in_ready  output  N  SHALL carry per-channel ready.
REQ-010 out_data  output  WIDTH  SHALL be the registered output data.
REQ-011 out_valid  output  1  SHALL be the registered output valid.
REQ-012 out_last  output  1  SHALL be the registered output last.
REQ-013 out_ready  input  1  SHALL be the downstream ready.

Function
REQ-014 A beat SHALL transfer on an input when in_valid[i] and in_ready[i] are both 1 in the same cycle, and on the output when out_valid and out_ready are both 1.
REQ-015 in_ready[i] SHALL be (i == active channel) and (out_valid == 0 or out_ready == 1); all other bits SHALL be 0.
REQ-016 An accepted input beat SHALL appear on out_data/out_last with out_valid = 1 exactly one cycle later (latency 1).
REQ-017 Sustained in_valid and out_ready SHALL give one beat per cycle, with no bubbles.
REQ-018 When out_valid = 1 and out_ready = 0, the output registers SHALL hold their values, and no input SHALL be ready.
REQ-019 When the output beat is consumed and there is no new input beat, out_valid SHALL go to 0 on the next edge.
REQ-020 If sel >= N (N not a power of two), no in_ready bit SHALL assert and no beat SHALL transfer.
REQ-021 in_data of non-selected channels SHALL have no effect on any output.

Reset
REQ-022 While rst = 1, out_valid, out_last and out_data SHALL be 0, the FSM SHALL be IDLE, and the latched channel SHALL be 0.
REQ-023 A reset asserted mid-packet SHALL discard the held beat and unlock the block, with no partial beat emitted after reset.
REQ-024 in_ready SHALL be 0 during the reset cycle.

Configuration
REQ-025 With macro STREAM_MUXN_LOCK_EN defined, the block SHALL use a two-state FSM (IDLE, LOCKED):
  - IDLE: the active channel is sel, evaluated combinationally.
  - On a transfer with in_last = 0, the block SHALL latch sel and go to LOCKED.
  - LOCKED: the active channel is the latched value and sel is ignored.
  - A transfer with in_last = 1 SHALL return the block to IDLE.
  - A single-beat packet (last on the first beat) SHALL stay in IDLE.
REQ-026 Without STREAM_MUXN_LOCK_EN, there SHALL be no FSM; the active channel SHALL be sel on every cycle, and in_last SHALL only be forwarded.

Structure
REQ-027 Package stream_muxn_pkg SHALL hold the state typedef (IDLE, LOCKED) and a function returning the channel-index width for N.
REQ-028 The output register stage SHALL be a sub-module reg_slice, parametrised by WIDTH+1 bits (data plus last), with a valid/ready pass-through.

Verification
REQ-029 Reset: assert rst for 2 cycles with in_valid = all ones -> out_valid = 0, out_data = 0, in_ready = 0 during reset.
REQ-030 Throughput: N = 4, sel = 2, channel 2 streams 0x1..0x8 with out_ready = 1 -> out_data = 0x1..0x8 on consecutive cycles, each 1 cycle after acceptance.
REQ-031 Backpressure: out_ready = 0 for 3 cycles with beat 0xAA held -> out_data stays 0xAA, in_ready = 0, no beat lost or duplicated.
REQ-032 Lock (LOCK_EN): switch sel 1 -> 3 mid-packet on a 4-beat channel-1 packet -> all 4 beats come from channel 1; the channel-3 beat follows after last.
REQ-033 No lock (no macro): switch sel 1 -> 3 mid-stream -> the next accepted beat comes from channel 3.
REQ-034 Edge cases: N = 3 with sel = 3 -> in_ready = 0 and no output. Reset mid-packet -> out_valid = 0 and the FSM returns to IDLE.

Source files
------------

// File: rtl/stream_muxn_pkg.sv
// Shared types and helpers for the stream_muxn N-to-1 stream multiplexer.
package stream_muxn_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Channel-index width for an n-input mux (n >= 2).
  function automatic int chan_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_slice.sv
// Single-entry valid/ready output register used by stream_muxn.
// Accepts a new word whenever the slot is empty or is being drained this cycle.
module reg_slice #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  input  logic         m_ready
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign s_ready = !valid_q || m_ready;
  assign m_valid = valid_q;
  assign m_data  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (s_ready) begin
      valid_q <= s_valid;
      if (s_valid) begin
        data_q <= s_data;
      end
    end
  end

endmodule

// File: rtl/stream_muxn.sv
// N-to-1 stream multiplexer with a registered output stage.
// Define STREAM_MUXN_LOCK_EN to hold the selected channel until the end of a packet.
module stream_muxn
  import stream_muxn_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [$clog2(N)-1:0]      sel,
  input  logic [N-1:0][WIDTH-1:0]   in_data,
  input  logic [N-1:0]              in_valid,
  input  logic [N-1:0]              in_last,
  output logic [N-1:0]              in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready
);

  localparam int SW = chan_w(N);

  logic [SW-1:0]    act_ch;
  logic [N-1:0]     rdy;
  logic             slice_rdy;
  logic             in_fire;
  logic             mux_last;
  logic [WIDTH-1:0] mux_data;
  logic [WIDTH:0]   slice_out;

`ifdef STREAM_MUXN_LOCK_EN
  state_e        state_q, state_d;
  logic [SW-1:0] chan_q, chan_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    case (state_q)
      IDLE: begin
        if (in_fire && !mux_last) begin
          state_d = LOCKED;
          chan_d  = sel;
        end
      end
      LOCKED: begin
        if (in_fire && mux_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    act_ch = (state_q == LOCKED) ? chan_q : sel;
  end
`else
  assign act_ch = sel;
`endif

  // An out-of-range selection matches no channel, so nothing is ready.
  always_comb begin
    rdy      = '0;
    mux_data = '0;
    mux_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (act_ch == SW'(i)) begin
        rdy[i]   = slice_rdy && !rst;
        mux_data = in_data[i];
        mux_last = in_last[i];
      end
    end
  end

  assign in_fire  = |(in_valid & rdy);
  assign in_ready = rdy;

  reg_slice #(
    .W(WIDTH + 1)
  ) u_slice (
    .clk     (clk),
    .rst     (rst),
    .s_valid (in_fire),
    .s_data  ({mux_last, mux_data}),
    .s_ready (slice_rdy),
    .m_valid (out_valid),
    .m_data  (slice_out),
    .m_ready (out_ready)
  );

  assign out_data = slice_out[WIDTH-1:0];
  assign out_last = slice_out[WIDTH];

endmodule

// File: tb/tb_stream_muxn.sv
// Randomised and directed bench for stream_muxn (N=4/WIDTH=64 and N=3/WIDTH=16 instances).
// Honours STREAM_MUXN_LOCK_EN the same way the design does.
module tb_stream_muxn;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            sel;
  logic [3:0]            in_valid;
  logic [3:0]            in_last;
  logic [3:0][63:0]      in_data;
  logic                  out_ready;

  logic [3:0]            in_ready_a;
  logic [63:0]           out_data_a;
  logic                  out_valid_a, out_last_a;

  logic [2:0][15:0]      in_data_b;
  logic [2:0]            in_ready_b;
  logic [15:0]           out_data_b;
  logic                  out_valid_b, out_last_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) in_data_b[i] = in_data[i][15:0];
  end

  stream_muxn #(.WIDTH(64), .N(4)) dut_a (
    .clk(clk), .rst(rst), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_a), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_last(out_last_a), .out_ready(out_ready)
  );

  stream_muxn #(.WIDTH(16), .N(3)) dut_b (
    .clk(clk), .rst(rst), .sel(sel), .in_data(in_data_b), .in_valid(in_valid[2:0]),
    .in_last(in_last[2:0]), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_last(out_last_b), .out_ready(out_ready)
  );

  // Behavioural reference: one output slot plus the packet-lock bookkeeping.
  typedef struct {
    bit          mv;
    logic [63:0] md;
    bit          ml;
    bit          lk;
    int          lch;
  } mdl_t;

  mdl_t ma = '{mv: 0, md: 64'h0, ml: 0, lk: 0, lch: 0};
  mdl_t mb = '{mv: 0, md: 64'h0, ml: 0, lk: 0, lch: 0};

  function automatic logic [3:0] exp_rdy(input mdl_t m, input int n);
    int act;
    act = m.lk ? m.lch : int'(sel);
    if (rst || act >= n || (m.mv && !out_ready)) return 4'b0;
    return 4'(1 << act);
  endfunction

  function automatic mdl_t advance(input mdl_t m, input int n, input logic [63:0] mask);
    mdl_t       q;
    int         act;
    logic [3:0] r;
    q   = m;
    act = m.lk ? m.lch : int'(sel);
    r   = exp_rdy(m, n);
    if (rst) begin
      q = '{mv: 0, md: 64'h0, ml: 0, lk: 0, lch: 0};
      return q;
    end
    if (m.mv && out_ready) q.mv = 0;
    if ((r & in_valid) != 4'b0) begin
      q.mv = 1;
      q.md = in_data[act] & mask;
      q.ml = in_last[act];
`ifdef STREAM_MUXN_LOCK_EN
      if (!m.lk && !in_last[act]) begin
        q.lk  = 1;
        q.lch = act;
      end else if (m.lk && in_last[act]) begin
        q.lk = 0;
      end
`endif
    end
    return q;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Check readiness for the current inputs, clock once, then check the registered outputs.
  task automatic tick();
    #1;
    chk("rdy_a", 64'(in_ready_a), 64'(exp_rdy(ma, 4)));
    chk("rdy_b", 64'(in_ready_b), 64'(exp_rdy(mb, 3)));
    @(posedge clk);
    ma = advance(ma, 4, {64{1'b1}});
    mb = advance(mb, 3, 64'hFFFF);
    #1;
    chk("vld_a",  64'(out_valid_a), 64'(ma.mv));
    chk("data_a", out_data_a, ma.md);
    chk("last_a", 64'(out_last_a), 64'(ma.ml));
    chk("vld_b",  64'(out_valid_b), 64'(mb.mv));
    chk("data_b", 64'(out_data_b), mb.md);
    chk("last_b", 64'(out_last_b), 64'(mb.ml));
  endtask

  initial begin
    rst = 1'b1; sel = 2'd0; in_valid = 4'hF; in_last = 4'h0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i] = {$urandom, $urandom};
    tick();
    tick();
    chk("rst_vld",  64'(out_valid_a), 64'h0);
    chk("rst_data", out_data_a, 64'h0);
    chk("rst_rdy",  64'(in_ready_a), 64'h0);
    rst = 1'b0;

    // Out-of-range select on the three-channel instance.
    sel = 2'd3; in_valid = 4'hF; in_last = 4'hF;
    tick();
    chk("n3_rdy", 64'(in_ready_b), 64'h0);
    chk("n3_vld", 64'(out_valid_b), 64'h0);
    in_valid = 4'h0;
    tick();

    // Throughput: channel 2 streams 1..8 back to back.
    sel = 2'd2; in_valid = 4'b0100; in_last = 4'h0;
    for (int i = 1; i <= 8; i++) begin
      in_data[2] = 64'(i);
      in_last[2] = (i == 8);
      tick();
      chk("thru_vld",  64'(out_valid_a), 64'h1);
      chk("thru_data", out_data_a, 64'(i));
    end
    in_valid = 4'h0;
    tick();

    // Backpressure holds 0xAA.
    in_valid = 4'b0100; in_data[2] = 64'hAA; in_last[2] = 1'b1;
    tick();
    chk("bp_first", out_data_a, 64'hAA);
    out_ready = 1'b0; in_data[2] = 64'hBB;
    repeat (3) begin
      tick();
      chk("bp_data", out_data_a, 64'hAA);
      chk("bp_rdy",  64'(in_ready_a), 64'h0);
    end
    out_ready = 1'b1; in_valid = 4'h0;
    tick();
    chk("bp_drain", 64'(out_valid_a), 64'h0);

    // Select switch in the middle of a packet.
`ifdef STREAM_MUXN_LOCK_EN
    sel = 2'd1; in_valid = 4'b1010; in_last = 4'b1000; in_data[3] = 64'h300;
    for (int k = 0; k < 4; k++) begin
      in_data[1] = 64'h101 + 64'(k);
      in_last[1] = (k == 3);
      tick();
      chk("lock_data", out_data_a, 64'h101 + 64'(k));
      if (k == 0) sel = 2'd3;
    end
    in_valid = 4'b1000;
    tick();
    chk("lock_after", out_data_a, 64'h300);
`else
    sel = 2'd1; in_valid = 4'b1010; in_last = 4'h0;
    in_data[1] = 64'h111; in_data[3] = 64'h333;
    tick();
    chk("nolock_first", out_data_a, 64'h111);
    sel = 2'd3;
    tick();
    chk("nolock_data", out_data_a, 64'h333);
`endif
    in_valid = 4'h0;
    tick();

    // Reset in the middle of a packet.
    sel = 2'd1; in_valid = 4'b0010; in_last = 4'h0; in_data[1] = 64'h55;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_vld", 64'(out_valid_a), 64'h0);
    rst = 1'b0; sel = 2'd3; in_valid = 4'b1000; in_data[3] = 64'h77; in_last[3] = 1'b1;
    tick();
    chk("midrst_data", out_data_a, 64'h77);
    in_valid = 4'h0;
    tick();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 49) == 0);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) in_data[i] = {$urandom, $urandom};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
